// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: PC+4 instruction fetch into a 2^IQ_ADDR_W entry issue queue; define ICACHE_EN to add a direct-mapped icache
module inst_fetch_queue #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          IQ_ADDR_W = 4
`ifdef ICACHE_EN
  , parameter int        ICACHE_IDX_W = 8
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy_in,
  output logic        mc_request_out,
  output logic [31:0] mc_addr_out,
  input  logic        mc_valid_in,
  input  logic [31:0] mc_inst_in,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic [31:0] flush_pc_in,
  output logic        dec_issue_signal_out,
  output logic [31:0] dec_inst_out,
  output logic [31:0] dec_pc_out
);
  localparam int DEPTH = 1 << IQ_ADDR_W;
  localparam int CNT_W = IQ_ADDR_W + 1;
  typedef enum logic {IDLE, WAIT_MEM} state_t;
  state_t               state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [IQ_ADDR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 discard_q, discard_d;
  logic                 req_d;
  logic [31:0]          addr_d;
  logic [31:0]          iq_pc_q [DEPTH];
  logic [31:0]          iq_inst_q [DEPTH];
  logic                 pop, mem_ret, room, fill, hit, push, launch;
  logic [31:0]          hit_inst, push_inst;
  // one slot stays reserved for the word of an outstanding request, so a launch needs two free slots
  assign room      = count_q < CNT_W'(DEPTH - 1);
  assign pop       = (count_q != '0) && !stall_in && !flush_in;
  assign mem_ret   = (state_q == WAIT_MEM) && mc_valid_in;
  assign fill      = mem_ret && !discard_q && !flush_in;
  assign push      = fill || (hit && room && !flush_in);
  assign launch    = (state_q == IDLE) && room && !flush_in && !hit;
  assign push_inst = fill ? mc_inst_in : hit_inst;
`ifdef ICACHE_EN
  localparam int LINES = 1 << ICACHE_IDX_W;
  localparam int TAG_W = 30 - ICACHE_IDX_W;
  logic [LINES-1:0]        ic_valid_q;
  logic [TAG_W-1:0]        ic_tag_q [LINES];
  logic [31:0]             ic_data_q [LINES];
  logic [ICACHE_IDX_W-1:0] ic_idx;
  assign ic_idx   = pc_q[ICACHE_IDX_W+1:2];
  assign hit      = (state_q == IDLE) && ic_valid_q[ic_idx] && (ic_tag_q[ic_idx] == pc_q[31:ICACHE_IDX_W+2]);
  assign hit_inst = ic_data_q[ic_idx];
  // line valid bits: set on a memory fill, never cleared by a flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ic_valid_q <= '0;
    else if (rdy_in && fill) ic_valid_q[ic_idx] <= 1'b1;
  end
  // line tag and data written alongside the valid bit
  always_ff @(posedge clk) begin
    if (rst && rdy_in && fill) begin
      ic_tag_q[ic_idx]  <= pc_q[31:ICACHE_IDX_W+2];
      ic_data_q[ic_idx] <= mc_inst_in;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_inst = '0;
`endif
  // next state; flush empties the queue, redirects pc and suppresses any push or pop
  always_comb begin
    state_d   = mem_ret ? IDLE : launch ? WAIT_MEM : state_q;
    discard_d = mem_ret ? 1'b0 : (flush_in && state_q == WAIT_MEM) ? 1'b1 : discard_q;
    pc_d      = flush_in ? flush_pc_in : push ? pc_q + 32'd4 : pc_q;
    count_d   = flush_in ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
    head_d    = flush_in ? tail_q : head_q + IQ_ADDR_W'(pop);
    tail_d    = tail_q + IQ_ADDR_W'(push);
    req_d     = launch ? 1'b1 : mem_ret ? 1'b0 : mc_request_out;
    addr_d    = launch ? pc_q : mc_addr_out;
  end
  // control state and registered outputs, frozen while rdy_in is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q              <= IDLE;
      pc_q                 <= RESET_PC;
      head_q               <= '0;
      tail_q               <= '0;
      count_q              <= '0;
      discard_q            <= 1'b0;
      mc_request_out       <= 1'b0;
      mc_addr_out          <= '0;
      dec_issue_signal_out <= 1'b0;
      dec_inst_out         <= '0;
      dec_pc_out           <= '0;
    end else if (rdy_in) begin
      state_q              <= state_d;
      pc_q                 <= pc_d;
      head_q               <= head_d;
      tail_q               <= tail_d;
      count_q              <= count_d;
      discard_q            <= discard_d;
      mc_request_out       <= req_d;
      mc_addr_out          <= addr_d;
      dec_issue_signal_out <= pop;
      if (pop) begin
        dec_inst_out <= iq_inst_q[head_q];
        dec_pc_out   <= iq_pc_q[head_q];
      end
    end
  end
  // queue storage, written at the tail on push
  always_ff @(posedge clk) begin
    if (rst && rdy_in && push) begin
      iq_pc_q[tail_q]   <= pc_q;
      iq_inst_q[tail_q] <= push_inst;
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed stimulus with a scoreboard of expected issue PCs checked by an independent monitor
module tb_inst_fetch_queue;
  logic        clk = 0, rst = 0, rdy_in = 0, mc_valid_in = 0, stall_in = 0, flush_in = 0;
  logic [31:0] mc_inst_in = 0, flush_pc_in = 0;
  logic        mc_request_out, dec_issue_signal_out;
  logic [31:0] mc_addr_out, dec_inst_out, dec_pc_out;
  int          checks = 0, errors = 0, n_issue = 0;
  logic [31:0] exp_q[$];
  logic        live_edge = 0;
  int          k, s;
  logic [31:0] a;

  inst_fetch_queue dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in),
    .mc_request_out(mc_request_out), .mc_addr_out(mc_addr_out),
    .mc_valid_in(mc_valid_in), .mc_inst_in(mc_inst_in),
    .stall_in(stall_in), .flush_in(flush_in), .flush_pc_in(flush_pc_in),
    .dec_issue_signal_out(dec_issue_signal_out), .dec_inst_out(dec_inst_out), .dec_pc_out(dec_pc_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] addr);
    return {addr[23:0], 8'h13};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic load(input logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < 100; i++) exp_q.push_back(base + 32'd4 * i);
  endtask

  // memory controller: answers each request 3 cycles later, frozen while rdy_in is low
  initial begin
    logic busy;
    int   cnt;
    busy = 0;
    cnt  = 0;
    forever begin
      @(posedge clk or negedge rst);
      #1;
      if (!rst) begin
        busy = 0;
        mc_valid_in = 0;
      end else if (rdy_in) begin
        if (mc_valid_in) begin
          mc_valid_in = 0;
          busy = 0;
        end else if (busy) begin
          cnt++;
          if (cnt == 2) begin
            mc_valid_in = 1;
            mc_inst_in  = inst_of(mc_addr_out);
          end
        end else if (mc_request_out) begin
          busy = 1;
          cnt  = 0;
        end
      end
    end
  end

  // an issue is new only if the preceding edge was live (rst high, rdy_in high)
  initial forever begin
    @(posedge clk);
    live_edge = rst && rdy_in;
  end

  // monitor: every issue pops the scoreboard and is compared
  initial forever begin
    logic [31:0] e;
    @(negedge clk);
    if (rst && live_edge && dec_issue_signal_out) begin
      n_issue++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL issue_unexpected actual_pc=%h required=none", dec_pc_out);
      end else begin
        e = exp_q.pop_front();
        chk("issue_pc", dec_pc_out, e);
        chk("issue_inst", dec_inst_out, inst_of(e));
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_req", mc_request_out, 0);
    chk("rst_addr", mc_addr_out, 0);
    chk("rst_issue", dec_issue_signal_out, 0);
    chk("rst_inst", dec_inst_out, 0);
    chk("rst_pc", dec_pc_out, 0);
    load(32'h0);
    rst = 1;
    rdy_in = 1;
    k = 0;
    while (!mc_request_out && k < 50) begin @(negedge clk); k++; end
    chk("first_req", mc_request_out, 1);
    chk("first_addr", mc_addr_out, 32'h0);
    k = 0;
    while (!mc_valid_in && k < 50) begin @(negedge clk); k++; end
    chk("first_valid", mc_valid_in, 1);
    @(negedge clk);
    chk("lat_early", dec_issue_signal_out, 0);
    @(negedge clk);
    chk("lat_issue", dec_issue_signal_out, 1);
    chk("lat_pc", dec_pc_out, 32'h0);
    k = 0;
    while (!(mc_request_out && mc_addr_out == 32'h20) && k < 200) begin @(negedge clk); k++; end
    chk("reach_20", mc_addr_out, 32'h20);
    flush_in = 1;
    flush_pc_in = 32'h1000;
    @(negedge clk);
    flush_in = 0;
    chk("issued_before_flush", n_issue, 8);
    load(32'h1000);
    k = 0;
    while (!(mc_request_out && mc_addr_out != 32'h20) && k < 50) begin @(negedge clk); k++; end
    chk("redirect_addr", mc_addr_out, 32'h1000);
    k = 0;
    while (n_issue < 10 && k < 100) begin @(negedge clk); k++; end
    chk("post_flush_issues", n_issue >= 10, 1);
    stall_in = 1;
    @(negedge clk);
    s = n_issue;
    repeat (79) @(negedge clk);
    chk("full_no_req", mc_request_out, 0);
    chk("stall_no_issue", n_issue, s);
    stall_in = 0;
    @(negedge clk);
    k = 0;
    while (dec_issue_signal_out && k < 64) begin @(negedge clk); k++; end
    chk("burst_ge16", k >= 16, 1);
    stall_in = 1;
    repeat (10) @(negedge clk);
    k = 0;
    while (!mc_valid_in && k < 50) begin @(negedge clk); k++; end
    chk("coinc_valid", mc_valid_in, 1);
    flush_in = 1;
    flush_pc_in = 32'h2000;
    stall_in = 0;
    @(negedge clk);
    flush_in = 0;
    chk("coinc_no_issue", dec_issue_signal_out, 0);
    load(32'h2000);
    k = 0;
    while (!mc_request_out && k < 50) begin @(negedge clk); k++; end
    chk("coinc_redirect", mc_addr_out, 32'h2000);
    s = n_issue;
    k = 0;
    while (n_issue < s + 2 && k < 100) begin @(negedge clk); k++; end
    chk("coinc_issues", n_issue >= s + 2, 1);
    k = 0;
    while (!mc_request_out && k < 50) begin @(negedge clk); k++; end
    a = mc_addr_out;
    rdy_in = 0;
    s = n_issue;
    repeat (6) @(negedge clk);
    chk("rdy_hold_req", mc_request_out, 1);
    chk("rdy_hold_addr", mc_addr_out, a);
    rdy_in = 1;
    k = 0;
    while (n_issue < s + 2 && k < 100) begin @(negedge clk); k++; end
    chk("rdy_resume", n_issue >= s + 2, 1);
    k = 0;
    while (!mc_request_out && k < 50) begin @(negedge clk); k++; end
    #2;
    rst = 0;
    #1;
    chk("arst_req", mc_request_out, 0);
    chk("arst_issue", dec_issue_signal_out, 0);
    chk("arst_pc", dec_pc_out, 0);
    @(negedge clk);
    load(32'h0);
    @(negedge clk);
    rst = 1;
    k = 0;
    while (!mc_request_out && k < 50) begin @(negedge clk); k++; end
    chk("restart_addr", mc_addr_out, 32'h0);
    s = n_issue;
    k = 0;
    while (n_issue < s + 2 && k < 100) begin @(negedge clk); k++; end
    chk("restart_issues", n_issue >= s + 2, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
